// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder: producer drives operands,
// consumer takes sum/cout/ovf once out_valid is seen.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder: A + B + CIN over WIDTH bits, STEP bits per clock through one
// rippled STEP-bit full-adder slice, with valid/ready handshake and signed overflow.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);
  localparam int NSTEP = WIDTH / STEP;
  localparam int CNT_W = $clog2(NSTEP + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic [WIDTH-1:0] a_next, b_next;
  logic             carry_reg, cout_reg, ovf_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [STEP-1:0]  slice_s;
  logic [STEP:0]    chain;
  logic             in_ready, accept, last_step;

  // One STEP-bit slice; chain[STEP-1] is the carry into the slice MSB.
  assign chain[0] = carry_reg;
  generate
    for (genvar gi = 0; gi < STEP; gi++) begin : g_fa
      assign slice_s[gi]   = a_reg[gi] ^ b_reg[gi] ^ chain[gi];
      assign chain[gi + 1] = (a_reg[gi] & b_reg[gi]) | (chain[gi] & (a_reg[gi] ^ b_reg[gi]));
    end
  endgenerate

  // Result bits fill the vacated top of the A shift register, so after NSTEP
  // steps a_reg holds the complete sum.
  generate
    if (STEP == WIDTH) begin : g_full
      assign a_next = slice_s;
    end else begin : g_part
      assign a_next = {slice_s, a_reg[WIDTH-1:STEP]};
    end
  endgenerate
  assign b_next = b_reg >> STEP;

  assign in_ready  = (state_reg == IDLE) && !rst;
  assign accept    = bus.in_valid && in_ready;
  assign last_step = (state_reg == RUN) && (cnt_reg == CNT_W'(NSTEP - 1));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)        state_next = RUN;
      RUN:     if (last_step)     state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      if (accept) begin
        a_reg     <= bus.a;
        b_reg     <= bus.b;
        carry_reg <= bus.cin;
        cnt_reg   <= '0;
      end else if (state_reg == RUN) begin
        a_reg     <= a_next;
        b_reg     <= b_next;
        carry_reg <= chain[STEP];
        if (!last_step) cnt_reg <= cnt_reg + CNT_W'(1);
      end
      if (last_step) begin
        sum_reg  <= a_next;
        cout_reg <= chain[STEP];
        ovf_reg  <= chain[STEP] ^ chain[STEP-1];
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_reg == DONE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;
  assign bus.ovf       = ovf_reg;
endmodule
